// File: rtl/fa16_rev_seq_ctrl.sv
// Sequencing controller for the 16-bit dual-rail reversible adder macro.
// Optional perf counters: define FA16_CTRL_PERF_EN.
module fa16_rev_seq_ctrl #(
    parameter int EVAL_CYCLES    = 2,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_cin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic        out_cout,
    output logic        out_err,
    output logic [15:0] drv_a,
    output logic [15:0] drv_a_not,
    output logic [15:0] drv_b,
    output logic [15:0] drv_b_not,
    output logic        drv_c0,
    output logic        drv_c0_not,
    output logic [15:0] drv_s,
    output logic [15:0] drv_s_not,
    output logic        drv_c15,
    output logic        drv_c15_not,
    output logic        drv_s_en,
    input  logic [15:0] fa_s,
    input  logic [15:0] fa_s_not,
    input  logic        fa_c15,
    input  logic        fa_c15_not,
    input  logic [15:0] fa_a_b,
    input  logic [15:0] fa_a_not_b
`ifdef FA16_CTRL_PERF_EN
    ,
    output logic [15:0] perf_ops,
    output logic [7:0]  perf_errs
`endif
);

    localparam int CW = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_FWD, S_CAPT, S_REV, S_CHECK, S_NULL, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [15:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic           cin_q, cin_d, cout_q, cout_d, err_q, err_d;
    logic           in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [15:0]    da_q, da_d, dan_q, dan_d, db_q, db_d, dbn_q, dbn_d;
    logic [15:0]    ds_q, ds_d, dsn_q, dsn_d;
    logic           dc0_q, dc0_d, dc0n_q, dc0n_d;
    logic           dc15_q, dc15_d, dc15n_q, dc15n_d, sen_q, sen_d;
    logic           s_bad, a_bad, fwd, rev;

    // A pair is bad when both rails match (null or fault).
    assign s_bad = (|(~(fa_s ^ fa_s_not))) | ~(fa_c15 ^ fa_c15_not);
    assign a_bad = (|(~(fa_a_b ^ fa_a_not_b))) | (fa_a_b != a_q);

    // Next-state, operand latch, capture and error accumulation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    cin_d   = in_cin;
                    err_d   = 1'b0;
                    cnt_d   = CW'(EVAL_CYCLES - 1);
                    state_d = S_FWD;
                end
            end
            S_FWD: begin
                if (cnt_q == '0) state_d = S_CAPT;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_CAPT: begin
                sum_d   = fa_s;
                cout_d  = fa_c15;
                err_d   = err_q | s_bad;
                cnt_d   = CW'(RECOVER_CYCLES - 1);
                state_d = S_REV;
            end
            S_REV: begin
                if (cnt_q == '0) state_d = S_CHECK;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_CHECK: begin
                err_d   = err_q | a_bad;
                state_d = S_NULL;
            end
            S_NULL: state_d = S_DONE;
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Rail drives for the state being entered, so they are registered.
    always_comb begin
        fwd         = (state_d == S_FWD) || (state_d == S_CAPT);
        rev         = (state_d == S_REV) || (state_d == S_CHECK);
        da_d        = fwd ? a_d : '0;
        dan_d       = fwd ? ~a_d : '0;
        db_d        = (fwd || rev) ? b_d : '0;
        dbn_d       = (fwd || rev) ? ~b_d : '0;
        dc0_d       = fwd & cin_d;
        dc0n_d      = fwd & ~cin_d;
        ds_d        = rev ? sum_d : '0;
        dsn_d       = rev ? ~sum_d : '0;
        dc15_d      = rev & cout_d;
        dc15n_d     = rev & ~cout_d;
        sen_d       = rev;
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            da_q        <= '0;
            dan_q       <= '0;
            db_q        <= '0;
            dbn_q       <= '0;
            dc0_q       <= 1'b0;
            dc0n_q      <= 1'b0;
            ds_q        <= '0;
            dsn_q       <= '0;
            dc15_q      <= 1'b0;
            dc15n_q     <= 1'b0;
            sen_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            da_q        <= da_d;
            dan_q       <= dan_d;
            db_q        <= db_d;
            dbn_q       <= dbn_d;
            dc0_q       <= dc0_d;
            dc0n_q      <= dc0n_d;
            ds_q        <= ds_d;
            dsn_q       <= dsn_d;
            dc15_q      <= dc15_d;
            dc15n_q     <= dc15n_d;
            sen_q       <= sen_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_sum     = sum_q;
    assign out_cout    = cout_q;
    assign out_err     = err_q;
    assign drv_a       = da_q;
    assign drv_a_not   = dan_q;
    assign drv_b       = db_q;
    assign drv_b_not   = dbn_q;
    assign drv_c0      = dc0_q;
    assign drv_c0_not  = dc0n_q;
    assign drv_s       = ds_q;
    assign drv_s_not   = dsn_q;
    assign drv_c15     = dc15_q;
    assign drv_c15_not = dc15n_q;
    assign drv_s_en    = sen_q;

`ifdef FA16_CTRL_PERF_EN
    logic [15:0] ops_q, ops_d;
    logic [7:0]  errs_q, errs_d;
    logic        hs;

    // Count completed results; error count saturates.
    always_comb begin
        hs     = out_valid_q & out_ready;
        ops_d  = ops_q + {15'd0, hs};
        errs_d = errs_q;
        if (hs && err_q && errs_q != 8'hFF) errs_d = errs_q + 8'd1;
    end

    // Perf counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ops_q  <= '0;
            errs_q <= '0;
        end else begin
            ops_q  <= ops_d;
            errs_q <= errs_d;
        end
    end

    assign perf_ops  = ops_q;
    assign perf_errs = errs_q;
`endif

endmodule

// File: tb/tb_fa16_rev_seq_ctrl.sv
// Directed bench for fa16_rev_seq_ctrl with a behavioural dual-rail macro.
// Fault and mismatch injection are controlled from the stimulus sequence.
module tb_fa16_rev_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [15:0] in_a, in_b;
    logic        in_cin;
    logic        out_valid, out_ready;
    logic [15:0] out_sum;
    logic        out_cout, out_err;
    logic [15:0] drv_a, drv_a_not, drv_b, drv_b_not, drv_s, drv_s_not;
    logic        drv_c0, drv_c0_not, drv_c15, drv_c15_not, drv_s_en;
    logic [15:0] fa_s, fa_s_not, fa_a_b, fa_a_not_b;
    logic        fa_c15, fa_c15_not;
`ifdef FA16_CTRL_PERF_EN
    logic [15:0] perf_ops;
    logic [7:0]  perf_errs;
`endif

    logic        tb_cin, inj_fault, inj_mis;
    logic [15:0] mis_val;
    logic [16:0] m_sum;
    logic [15:0] m_rec;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    fa16_rev_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_err(out_err),
        .drv_a(drv_a), .drv_a_not(drv_a_not),
        .drv_b(drv_b), .drv_b_not(drv_b_not),
        .drv_c0(drv_c0), .drv_c0_not(drv_c0_not),
        .drv_s(drv_s), .drv_s_not(drv_s_not),
        .drv_c15(drv_c15), .drv_c15_not(drv_c15_not),
        .drv_s_en(drv_s_en),
        .fa_s(fa_s), .fa_s_not(fa_s_not),
        .fa_c15(fa_c15), .fa_c15_not(fa_c15_not),
        .fa_a_b(fa_a_b), .fa_a_not_b(fa_a_not_b)
`ifdef FA16_CTRL_PERF_EN
        , .perf_ops(perf_ops), .perf_errs(perf_errs)
`endif
    );

    // Ideal macro: forward add when A rails are live, uncompute when s_en.
    always_comb begin
        fa_s       = '0;
        fa_s_not   = '0;
        fa_c15     = 1'b0;
        fa_c15_not = 1'b0;
        fa_a_b     = '0;
        fa_a_not_b = '0;
        m_sum      = '0;
        m_rec      = '0;
        if ((drv_a | drv_a_not) != 16'h0) begin
            m_sum      = {1'b0, drv_a} + {1'b0, drv_b} + {16'd0, drv_c0};
            fa_s       = m_sum[15:0];
            fa_s_not   = ~m_sum[15:0];
            fa_c15     = m_sum[16];
            fa_c15_not = ~m_sum[16];
            if (inj_fault) begin
                fa_s[7]     = 1'b1;
                fa_s_not[7] = 1'b1;
            end
        end
        if (drv_s_en) begin
            m_rec = drv_s - drv_b - {15'd0, tb_cin};
            if (inj_mis) m_rec = mis_val;
            fa_a_b     = m_rec;
            fa_a_not_b = ~m_rec;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rails_or();
        return 32'(|{drv_a, drv_a_not, drv_b, drv_b_not, drv_c0,
                     drv_c0_not, drv_s, drv_s_not, drv_c15,
                     drv_c15_not, drv_s_en});
    endfunction

    // Offer an operand pair and wait (bounded) for the acceptance edge.
    task automatic offer(input logic [15:0] a, input logic [15:0] b,
                         input logic c);
        int n;
        in_a     = a;
        in_b     = b;
        in_cin   = c;
        tb_cin   = c;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("offer_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Full transaction: latency, null phases, result, optional backpressure.
    task automatic txn(input string tag, input logic [15:0] a,
                       input logic [15:0] b, input logic c,
                       input logic chk_sum, input logic [15:0] e_sum,
                       input logic e_cout, input logic e_err, input int hold);
        offer(a, b, c);
        for (int k = 1; k <= 8; k++) begin
            if (k >= 4 && k <= 7)
                chk({tag, "_a_null"}, 32'(|{drv_a, drv_a_not, drv_c0,
                                            drv_c0_not}), 32'd0);
            if (k == 7) chk({tag, "_all_null"}, rails_or(), 32'd0);
            if (k == 8) begin
                if (hold == 0) out_ready = 1'b1;
            end else begin
                chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
                @(negedge clk);
            end
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_busy"}, 32'(in_ready), 32'd0);
        if (chk_sum) chk({tag, "_sum"}, 32'(out_sum), 32'(e_sum));
        chk({tag, "_cout"}, 32'(out_cout), 32'(e_cout));
        chk({tag, "_err"}, 32'(out_err), 32'(e_err));
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold"}, {13'd0, out_valid, in_ready, out_cout,
                                 out_err, out_sum},
                {13'd0, 1'b1, 1'b0, e_cout, e_err, e_sum});
        end
        if (hold != 0) out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        tb_cin    = 1'b0;
        inj_fault = 1'b0;
        inj_mis   = 1'b0;
        mis_val   = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_rails", rails_or(), 32'd0);
        chk("rst_out", {15'd0, out_cout, out_sum}, 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", 32'(in_ready), 32'd1);

        txn("basic", 16'h1234, 16'h0FED, 1'b0, 1'b1, 16'h2221, 1'b0, 1'b0, 0);
        chk("idle_keep_sum", 32'(out_sum), 32'h2221);
        txn("wrap", 16'hFFFF, 16'h0001, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 0);

        inj_fault = 1'b1;
        txn("fault", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 0);
        inj_fault = 1'b0;
        txn("clean", 16'h0003, 16'h0004, 1'b0, 1'b1, 16'h0007, 1'b0, 1'b0, 0);

        inj_mis = 1'b1;
        mis_val = 16'h00FF;
        txn("mismatch", 16'h00FE, 16'h0100, 1'b0, 1'b1, 16'h01FE, 1'b0,
            1'b1, 0);
        inj_mis = 1'b0;

        txn("bp", 16'h8000, 16'h8000, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 5);

        offer(16'h0555, 16'h0AAA, 1'b0);
        repeat (3) @(negedge clk);
        chk("mid_in_rev", 32'(drv_s_en), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rails", rails_or(), 32'd0);
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("mid_no_result", 32'(out_valid), 32'd0);
        end
        txn("after_rst", 16'h0555, 16'h0AAA, 1'b0, 1'b1, 16'h0FFF, 1'b0,
            1'b0, 0);
`ifdef FA16_CTRL_PERF_EN
        chk("perf_ops", 32'(perf_ops), 32'd1);
        chk("perf_errs", 32'(perf_errs), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
